i2c_tx_engine: RTL and testbench
================================

Name: i2c_tx_engine

Overview:
Parametrised next-generation I2C transmit bit engine. It owns its own frame shift register and accepts frames over a valid/ready handshake. It serialises each frame onto SDA with a programmable post-SCL-fall hold time, detects arbitration loss, and samples the receiver ACK/NACK. It sits between the master/slave controller and the open-drain pad logic, and replaces the fixed 8-bit transmitter that needed an external shifter.

Parameters:
DATA_W, 8, bits per frame before the ACK slot (range 1..16)
HOLD_CYC, 2, clk cycles SDA keeps its previous value after SCL falls (range 0..255)
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > DATA_W

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
enable  input  1  transmit enable from the controller; low forces IDLE
stop_det  input  1  one-cycle pulse on a detected STOP condition
scl_in  input  1  synchronised SCL line level
sda_in  input  1  synchronised SDA line level
tx_data  input  DATA_W  frame to send, MSB first
tx_valid  input  1  tx_data is valid
tx_ready  output  1  one-cycle accept strobe; frame is consumed when tx_valid & tx_ready
sda_out  output  1  SDA drive value (0 = pull low, 1 = release)
arb_lost  output  1  one-cycle pulse on arbitration loss
ack_valid  output  1  one-cycle pulse when the ACK bit has been sampled
ack_nack  output  1  sampled ACK bit (1 = NACK); held until the next ack_valid
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async): state=IDLE; sda_out=1; tx_ready=0; arb_lost=0; ack_valid=0; ack_nack=0; busy=0; hold counter=0; bit_cnt=0; scl_q=1.
- Edge detect: scl_q registers scl_in. rise = scl_in & ~scl_q; fall = ~scl_in & scl_q.
- Hold logic: a fall loads hold_cnt=HOLD_CYC. While hold_cnt!=0, sda_out keeps its prior value and the counter decrements. At 0 the new bit is driven. HOLD_CYC=0 drives the new bit in the cycle after the fall.
- Outputs are registered; sda_out changes on clk edges only.
- States:
  - IDLE: sda_out=1. If enable & tx_valid & ~scl_in: tx_ready=1, load shifter, bit_cnt=0, go to CLKLO.
  - CLKLO: drive shifter MSB once the hold time has expired. On rise: if the driven bit is 1 and sda_in is 0, pulse arb_lost, set sda_out=1, go to IDLE; otherwise go to CLKHI.
  - CLKHI: keep the bit. On fall: shift left and increment bit_cnt. If bit_cnt==DATA_W-1, go to ACKLO; otherwise go to CLKLO.
  - ACKLO: sda_out=1 after the hold time. On rise: ack_valid=1, ack_nack=sda_in, go to ACKHI.
  - ACKHI: on fall, if enable & tx_valid & ~ack_nack: tx_ready=1, load the next frame, bit_cnt=0, go to CLKLO. Otherwise go to IDLE.
- Priority: stop_det or ~enable in any state wins over all other transitions. Next state is IDLE, sda_out=1 the next cycle, and no arb_lost or ack_valid pulse is issued that cycle.
- A rise and a stop_det in the same cycle resolve to IDLE.
- Arbitration is checked only at the rise in CLKLO, never in the ACK slot.
- tx_ready never asserts without tx_valid. Data is taken in the tx_ready cycle only.
- Frames are transmitted back to back without returning to IDLE, on ACK only.

Optional Feature:
Macro I2C_TX_CLK_STRETCH_EN.
- Defined: adds output scl_out (1 = release, reset 1). After the ACKHI fall with ~ack_nack & enable & ~tx_valid, the engine enters state STRETCH and drives scl_out=0 while sda_out=1. When tx_valid rises it accepts the frame (tx_ready=1) and goes to CLKLO. scl_out releases one cycle after the frame is loaded with the first bit already driven. stop_det or ~enable releases SCL immediately.
- Undefined: no scl_out port and no STRETCH state; this case goes to IDLE.

Decomposition:
- Package i2c_tx_pkg holds the state encoding constants (IDLE, CLKLO, CLKHI, ACKLO, ACKHI, STRETCH) and the default DATA_W and HOLD_CYC values.
- One natural sub-module: i2c_hold_timer (loadable down-counter with an expired flag), instantiated once.

Test Plan:
- Reset asserted mid-frame (state CLKHI) -> all outputs at reset values within the same cycle; busy=0.
- DATA_W=8, HOLD_CYC=2, tx_data=0xA5, receiver ACK -> SDA bit sequence 1,0,1,0,0,1,0,1; each change lands exactly 3 clk after the SCL fall; ack_valid pulse with ack_nack=0.
- Two frames 0x3C then 0xF0 with tx_valid held -> second tx_ready pulses exactly 1 cycle after the ACK-slot SCL fall; no IDLE between frames.
- Driving bit 1 while another master pulls SDA low at a rise -> arb_lost for 1 cycle, sda_out=1, state IDLE.
- NACK (sda_in=1 in ACK slot) with tx_valid high -> ack_nack=1, no tx_ready, IDLE after the fall.
- With I2C_TX_CLK_STRETCH_EN: ACK and tx_valid low for 20 cycles -> scl_out=0 for the whole 20 cycles; tx_valid=1 -> tx_ready pulse, then scl_out=1.

Source files
------------

// File: rtl/i2c_tx_engine_pkg.sv
// Shared constants for the I2C transmit bit engine: FSM state encoding and
// default frame/hold parameters.
package i2c_tx_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_HOLD_CYC = 2;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLKLO   = 3'd1;
  localparam logic [2:0] CLKHI   = 3'd2;
  localparam logic [2:0] ACKLO   = 3'd3;
  localparam logic [2:0] ACKHI   = 3'd4;
  localparam logic [2:0] STRETCH = 3'd5;

endpackage

// File: rtl/i2c_tx_engine_if.sv
// Controller/pad-side bundle of the I2C transmit engine.
// Optional macro I2C_TX_CLK_STRETCH_EN adds the scl_out line.
interface i2c_tx_engine_if import i2c_tx_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
);
  logic              enable;
  logic              stop_det;
  logic              scl_in;
  logic              sda_in;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              sda_out;
  logic              arb_lost;
  logic              ack_valid;
  logic              ack_nack;
  logic              busy;
`ifdef I2C_TX_CLK_STRETCH_EN
  logic              scl_out;
`endif

  // Handshake: tx_ready is a registered one-cycle strobe raised only while
  // tx_valid is high; the frame on tx_data is captured on the same clock edge
  // that raises tx_ready, so the producer may change tx_data once it sees it.
`ifdef I2C_TX_CLK_STRETCH_EN
  modport slave (
    input  enable, stop_det, scl_in, sda_in, tx_data, tx_valid,
    output tx_ready, sda_out, arb_lost, ack_valid, ack_nack, busy, scl_out
  );
  modport master (
    output enable, stop_det, scl_in, sda_in, tx_data, tx_valid,
    input  tx_ready, sda_out, arb_lost, ack_valid, ack_nack, busy, scl_out
  );
`else
  modport slave (
    input  enable, stop_det, scl_in, sda_in, tx_data, tx_valid,
    output tx_ready, sda_out, arb_lost, ack_valid, ack_nack, busy
  );
  modport master (
    output enable, stop_det, scl_in, sda_in, tx_data, tx_valid,
    input  tx_ready, sda_out, arb_lost, ack_valid, ack_nack, busy
  );
`endif

endinterface

// File: rtl/i2c_tx_engine_hold_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module i2c_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_tx_engine.sv
// I2C transmit bit engine: serialises frames MSB first with a post-fall SDA
// hold, flags arbitration loss and samples ACK. Macro I2C_TX_CLK_STRETCH_EN
// enables SCL stretching while waiting for the next frame.
module i2c_tx_engine import i2c_tx_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  i2c_tx_engine_if.slave  tx_if,
  output logic [2:0]      state_o
);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              sda_q, sda_d;
  logic              tx_ready_q, tx_ready_d;
  logic              arb_lost_q, arb_lost_d;
  logic              ack_valid_q, ack_valid_d;
  logic              ack_nack_q, ack_nack_d;
  logic              scl_q;
  logic              rise, fall, hold_expired;
`ifdef I2C_TX_CLK_STRETCH_EN
  logic              scl_out_q, scl_out_d;
`endif

  assign rise = tx_if.scl_in & ~scl_q;
  assign fall = ~tx_if.scl_in & scl_q;

  i2c_hold_timer #(.W(8)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load_i     (fall),
    .load_val_i (8'(HOLD_CYC)),
    .expired_o  (hold_expired)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    sda_d       = sda_q;
    tx_ready_d  = 1'b0;
    arb_lost_d  = 1'b0;
    ack_valid_d = 1'b0;
    ack_nack_d  = ack_nack_q;
`ifdef I2C_TX_CLK_STRETCH_EN
    scl_out_d   = scl_out_q;
`endif
    // Abort paths override every other transition, including a same-cycle rise.
    if (tx_if.stop_det || !tx_if.enable) begin
      state_d = IDLE;
      sda_d   = 1'b1;
`ifdef I2C_TX_CLK_STRETCH_EN
      scl_out_d = 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          sda_d = 1'b1;
`ifdef I2C_TX_CLK_STRETCH_EN
          scl_out_d = 1'b1;
`endif
          if (tx_if.tx_valid && !tx_if.scl_in) begin
            tx_ready_d = 1'b1;
            shift_d    = tx_if.tx_data;
            bit_cnt_d  = '0;
            state_d    = CLKLO;
          end
        end
        CLKLO: begin
          if (rise) begin
            if (sda_q && !tx_if.sda_in) begin
              arb_lost_d = 1'b1;
              sda_d      = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = CLKHI;
            end
          end else if (hold_expired) begin
            sda_d = shift_q[DATA_W-1];
          end
`ifdef I2C_TX_CLK_STRETCH_EN
          // Let SCL go only once the first bit is already on the line.
          if (!scl_out_q && hold_expired && (sda_q == shift_q[DATA_W-1])) begin
            scl_out_d = 1'b1;
          end
`endif
        end
        CLKHI: begin
          if (fall) begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = (bit_cnt_q == CNT_W'(DATA_W - 1)) ? ACKLO : CLKLO;
          end
        end
        ACKLO: begin
          if (rise) begin
            ack_valid_d = 1'b1;
            ack_nack_d  = tx_if.sda_in;
            state_d     = ACKHI;
          end else if (hold_expired) begin
            sda_d = 1'b1;
          end
        end
        ACKHI: begin
          if (fall) begin
            if (tx_if.tx_valid && !ack_nack_q) begin
              tx_ready_d = 1'b1;
              shift_d    = tx_if.tx_data;
              bit_cnt_d  = '0;
              state_d    = CLKLO;
`ifdef I2C_TX_CLK_STRETCH_EN
            end else if (!ack_nack_q) begin
              state_d   = STRETCH;
              scl_out_d = 1'b0;
              sda_d     = 1'b1;
`endif
            end else begin
              state_d = IDLE;
            end
          end
        end
`ifdef I2C_TX_CLK_STRETCH_EN
        STRETCH: begin
          sda_d     = 1'b1;
          scl_out_d = 1'b0;
          if (tx_if.tx_valid) begin
            tx_ready_d = 1'b1;
            shift_d    = tx_if.tx_data;
            bit_cnt_d  = '0;
            state_d    = CLKLO;
            if (hold_expired) begin
              sda_d = tx_if.tx_data[DATA_W-1];
            end
          end
        end
`endif
        default: begin
          state_d = IDLE;
          sda_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      sda_q       <= 1'b1;
      tx_ready_q  <= 1'b0;
      arb_lost_q  <= 1'b0;
      ack_valid_q <= 1'b0;
      ack_nack_q  <= 1'b0;
      scl_q       <= 1'b1;
`ifdef I2C_TX_CLK_STRETCH_EN
      scl_out_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      sda_q       <= sda_d;
      tx_ready_q  <= tx_ready_d;
      arb_lost_q  <= arb_lost_d;
      ack_valid_q <= ack_valid_d;
      ack_nack_q  <= ack_nack_d;
      scl_q       <= tx_if.scl_in;
`ifdef I2C_TX_CLK_STRETCH_EN
      scl_out_q   <= scl_out_d;
`endif
    end
  end

  assign tx_if.tx_ready  = tx_ready_q;
  assign tx_if.sda_out   = sda_q;
  assign tx_if.arb_lost  = arb_lost_q;
  assign tx_if.ack_valid = ack_valid_q;
  assign tx_if.ack_nack  = ack_nack_q;
  assign tx_if.busy      = (state_q != IDLE);
`ifdef I2C_TX_CLK_STRETCH_EN
  assign tx_if.scl_out   = scl_out_q;
`endif
  assign state_o         = state_q;

endmodule

// File: tb/tb_i2c_tx_engine.sv
// Self-checking bench for i2c_tx_engine; SCL is generated here with 8-cycle
// low/high phases and SDA is a wired-AND of the engine and an external device.
module tb_i2c_tx_engine;
  import i2c_tx_pkg::*;

  localparam int DW   = 8;
  localparam int HOLD = 2;
  localparam int LO   = 8;
  localparam int HI   = 8;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       ext_low;
  logic [2:0] state;
  logic [0:0] exp_q[$];
  int         n_cmp;
  int         n_err;

  i2c_tx_engine_if #(.DATA_W(DW)) bus ();

`ifdef I2C_TX_CLK_STRETCH_EN
  assign bus.scl_in = scl_m & bus.scl_out;
`else
  assign bus.scl_in = scl_m;
`endif
  assign bus.sda_in = bus.sda_out & ~ext_low;

  i2c_tx_engine #(.DATA_W(DW), .HOLD_CYC(HOLD), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_if   (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_frame(input logic [DW-1:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(d[i]);
  endtask

  task automatic wait_ready(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.tx_ready;
    end
    check_eq(tag, seen, 1);
  endtask

  // One data bit slot; 'done' negedges of the low phase have already elapsed.
  task automatic data_slot(input bit timed, input int done);
    logic old_b, new_b, exp_b;
    old_b = bus.sda_out;
    new_b = (exp_q.size() != 0) ? exp_q[0] : 1'bx;
    for (int i = done + 1; i <= LO; i++) begin
      @(negedge clk);
      if (timed && (old_b !== new_b)) begin
        if (i == HOLD + 1) check_eq("sda_hold", bus.sda_out, old_b);
        if (i == HOLD + 2) check_eq("sda_launch", bus.sda_out, new_b);
      end
    end
    exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
    check_eq("sda_bit", bus.sda_out, exp_b);
    scl_m = 1'b1;
    repeat (HI) @(negedge clk);
    scl_m = 1'b0;
  endtask

  task automatic data_bits(input bit timed0, input int done0);
    data_slot(timed0, done0);
    for (int i = 1; i < DW; i++) data_slot(1'b1, 0);
  endtask

  task automatic ack_slot(input bit nack);
    ext_low = ~nack;
    repeat (LO) @(negedge clk);
    check_eq("ack_release", bus.sda_out, 1);
    scl_m = 1'b1;
    @(negedge clk);
    check_eq("ack_valid", bus.ack_valid, 1);
    check_eq("ack_nack", bus.ack_nack, nack);
    check_eq("ack_no_arb", bus.arb_lost, 0);
    @(negedge clk);
    check_eq("ack_valid_pulse", bus.ack_valid, 0);
    repeat (HI - 2) @(negedge clk);
    scl_m   = 1'b0;
    ext_low = 1'b0;
  endtask

  // After an ACKed frame with no new data the engine idles (or stretches).
  task automatic finish_ack_frame();
    @(negedge clk);
`ifdef I2C_TX_CLK_STRETCH_EN
    check_eq("stretch_enter", bus.scl_out, 0);
    bus.enable = 1'b0;
    @(negedge clk);
    check_eq("stretch_abort_scl", bus.scl_out, 1);
    check_eq("stretch_abort_busy", bus.busy, 0);
    bus.enable = 1'b1;
`else
    check_eq("idle_after_ack", bus.busy, 0);
`endif
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic stretch_low;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    scl_m = 1'b0;
    ext_low = 1'b0;
    bus.enable = 1'b1;
    bus.stop_det = 1'b0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sda", bus.sda_out, 1);
    check_eq("rst_ready", bus.tx_ready, 0);
    check_eq("rst_arb", bus.arb_lost, 0);
    check_eq("rst_ackv", bus.ack_valid, 0);
    check_eq("rst_nack", bus.ack_nack, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_state", state, IDLE);
`ifdef I2C_TX_CLK_STRETCH_EN
    check_eq("rst_scl_out", bus.scl_out, 1);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame 0xA5 with ACK
    drive_frame(8'hA5);
    wait_ready("rdy_a5");
    bus.tx_valid = 1'b0;
    check_eq("busy_a5", bus.busy, 1);
    data_bits(1'b0, 0);
    ack_slot(1'b0);
    finish_ack_frame();

    // Back-to-back 0x3C then 0xF0
    drive_frame(8'h3C);
    wait_ready("rdy_3c");
    drive_frame(8'hF0);
    data_bits(1'b0, 0);
    ack_slot(1'b0);
    @(negedge clk);
    check_eq("rdy_b2b", bus.tx_ready, 1);
    check_eq("busy_b2b", bus.busy, 1);
    bus.tx_valid = 1'b0;
    data_bits(1'b1, 1);
    ack_slot(1'b0);
    finish_ack_frame();

`ifdef I2C_TX_CLK_STRETCH_EN
    drive_frame(8'h81);
    wait_ready("rdy_st");
    bus.tx_valid = 1'b0;
    data_bits(1'b0, 0);
    ack_slot(1'b0);
    stretch_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.scl_out !== 1'b0) stretch_low = 1'b0;
    end
    check_eq("stretch_hold", stretch_low, 1);
    check_eq("stretch_busy", bus.busy, 1);
    drive_frame(8'h42);
    @(negedge clk);
    check_eq("stretch_rdy", bus.tx_ready, 1);
    check_eq("stretch_still_low", bus.scl_out, 0);
    bus.tx_valid = 1'b0;
    @(negedge clk);
    check_eq("stretch_release", bus.scl_out, 1);
    check_eq("stretch_rdy_pulse", bus.tx_ready, 0);
    check_eq("stretch_first_bit", bus.sda_out, exp_q[0]);
    data_bits(1'b0, 1);
    ack_slot(1'b1);
    @(negedge clk);
    check_eq("stretch_nack_idle", bus.busy, 0);
    repeat (2) @(negedge clk);
`else
    stretch_low = 1'b0;
`endif

    // NACK with a new frame pending: no accept, back to IDLE
    drive_frame(8'h5A);
    wait_ready("rdy_5a");
    bus.tx_valid = 1'b0;
    data_bits(1'b0, 0);
    bus.tx_data  = 8'h11;
    bus.tx_valid = 1'b1;
    ack_slot(1'b1);
    @(negedge clk);
    check_eq("nack_no_ready", bus.tx_ready, 0);
    check_eq("nack_idle", bus.busy, 0);
    bus.tx_valid = 1'b0;
    @(negedge clk);
    check_eq("nack_no_ready2", bus.tx_ready, 0);
    check_eq("sb_drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // stop_det coinciding with a rise that would otherwise lose arbitration
    drive_frame(8'hFF);
    wait_ready("rdy_ff");
    bus.tx_valid = 1'b0;
    repeat (LO) @(negedge clk);
    check_eq("stop_bit", bus.sda_out, exp_q.pop_front());
    scl_m = 1'b1;
    ext_low = 1'b1;
    bus.stop_det = 1'b1;
    @(negedge clk);
    bus.stop_det = 1'b0;
    check_eq("stop_no_arb", bus.arb_lost, 0);
    check_eq("stop_idle", bus.busy, 0);
    check_eq("stop_sda", bus.sda_out, 1);
    exp_q.delete();
    repeat (HI - 1) @(negedge clk);
    scl_m = 1'b0;
    ext_low = 1'b0;
    repeat (2) @(negedge clk);

    // enable dropped while a 0 is driven
    drive_frame(8'h00);
    wait_ready("rdy_00");
    bus.tx_valid = 1'b0;
    repeat (LO) @(negedge clk);
    check_eq("en_bit", bus.sda_out, exp_q.pop_front());
    bus.enable = 1'b0;
    @(negedge clk);
    check_eq("en_release", bus.sda_out, 1);
    check_eq("en_idle", bus.busy, 0);
    bus.enable = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);

    // Arbitration loss on a driven 1
    drive_frame(8'h80);
    wait_ready("rdy_80");
    bus.tx_valid = 1'b0;
    repeat (LO) @(negedge clk);
    check_eq("arb_bit", bus.sda_out, exp_q.pop_front());
    scl_m = 1'b1;
    ext_low = 1'b1;
    @(negedge clk);
    check_eq("arb_pulse", bus.arb_lost, 1);
    check_eq("arb_sda", bus.sda_out, 1);
    check_eq("arb_idle", bus.busy, 0);
    check_eq("arb_state", state, IDLE);
    @(negedge clk);
    check_eq("arb_one_cycle", bus.arb_lost, 0);
    exp_q.delete();
    repeat (HI - 2) @(negedge clk);
    scl_m = 1'b0;
    ext_low = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in CLKHI
    drive_frame(8'h16);
    wait_ready("rdy_16");
    bus.tx_valid = 1'b0;
    repeat (LO) @(negedge clk);
    scl_m = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_state", state, CLKHI);
    check_eq("pre_rst_nack", bus.ack_nack, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_sda", bus.sda_out, 1);
    check_eq("arst_ready", bus.tx_ready, 0);
    check_eq("arst_nack", bus.ack_nack, 0);
    check_eq("arst_state", state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    scl_m = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
